// File: rtl/ray_pkg.sv
// Shared types and constants for the ray marching pipeline.
package ray_pkg;

  localparam int unsigned COORD_W        = 32;
  localparam int unsigned CAM_W          = 11;
  localparam int unsigned RAD_W          = 64;
  localparam int unsigned DIST_W         = 2 * COORD_W + 2;
  localparam int unsigned FRAC_BITS_DEF  = 8;
  localparam int unsigned STEP_SHIFT_DEF = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    TEST = 2'd1,
    STEP = 2'd2,
    DONE = 2'd3
  } march_state_t;

  // Exact square of a signed coordinate difference, zero-extended to DIST_W.
  function automatic logic [DIST_W-1:0] square_exact(input logic signed [COORD_W-1:0] v);
    logic signed [2*COORD_W-1:0] w;
    w = (2 * COORD_W)'(v);
    return DIST_W'(unsigned'(w * w));
  endfunction

endpackage

// File: rtl/ray_dist_sq.sv
// Combinational squared Euclidean distance from three signed axis differences.
module ray_dist_sq
  import ray_pkg::*;
(
  input  logic signed [COORD_W-1:0] dx,
  input  logic signed [COORD_W-1:0] dy,
  input  logic signed [COORD_W-1:0] dz,
  output logic        [DIST_W-1:0]  dist2_c
);

  always_comb begin
    dist2_c = square_exact(dx) + square_exact(dy) + square_exact(dz);
  end

endmodule

// File: rtl/ray_marcher.sv
// Marches one camera ray in fixed-point steps until it hits a sphere or runs out of steps.
module ray_marcher
  import ray_pkg::*;
#(
  parameter int unsigned FRAC_BITS  = FRAC_BITS_DEF,
  parameter int unsigned STEP_SHIFT = STEP_SHIFT_DEF,
  parameter int unsigned MAX_STEPS  = 1023,
  parameter int unsigned STEP_W     = $clog2(MAX_STEPS + 1)
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic        [CAM_W-1:0]   camera_pos_x,
  input  logic        [CAM_W-1:0]   camera_pos_y,
  input  logic        [CAM_W-1:0]   camera_pos_z,
  input  logic signed [COORD_W-1:0] ray_dir_x,
  input  logic signed [COORD_W-1:0] ray_dir_y,
  input  logic signed [COORD_W-1:0] ray_dir_z,
  input  logic signed [COORD_W-1:0] sphere_x,
  input  logic signed [COORD_W-1:0] sphere_y,
  input  logic signed [COORD_W-1:0] sphere_z,
  input  logic        [RAD_W-1:0]   radius_sq,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      hit,
  output logic        [STEP_W-1:0]  step_count,
  output logic signed [COORD_W-1:0] hit_x,
  output logic signed [COORD_W-1:0] hit_y,
  output logic signed [COORD_W-1:0] hit_z
);

  localparam int unsigned DELTA_SHIFT = FRAC_BITS - STEP_SHIFT;

  if (STEP_SHIFT > FRAC_BITS) begin : g_param_check
    $error("ray_marcher: STEP_SHIFT must not exceed FRAC_BITS");
  end

  march_state_t               state_q, state_d;
  logic                       in_ready_q, in_ready_d;
  logic                       out_valid_q, out_valid_d;
  logic                       hit_q, hit_d;
  logic        [STEP_W-1:0]   step_cnt_q, step_cnt_d;
  logic        [STEP_W-1:0]   step_count_q, step_count_d;
  logic        [RAD_W-1:0]    rad_q, rad_d;
  logic signed [COORD_W-1:0]  pos_q [3];
  logic signed [COORD_W-1:0]  pos_d [3];
  logic signed [COORD_W-1:0]  delta_q [3];
  logic signed [COORD_W-1:0]  delta_d [3];
  logic signed [COORD_W-1:0]  sph_q [3];
  logic signed [COORD_W-1:0]  sph_d [3];
  logic signed [COORD_W-1:0]  hit_pos_q [3];
  logic signed [COORD_W-1:0]  hit_pos_d [3];
  logic signed [COORD_W-1:0]  ipos [3];
  logic signed [COORD_W-1:0]  diff [3];
  logic        [DIST_W-1:0]   dist2_c;
  logic        [CAM_W-1:0]    cam_in [3];
  logic signed [COORD_W-1:0]  dir_in [3];
  logic signed [COORD_W-1:0]  sph_in [3];

  assign cam_in = '{camera_pos_x, camera_pos_y, camera_pos_z};
  assign dir_in = '{ray_dir_x, ray_dir_y, ray_dir_z};
  assign sph_in = '{sphere_x, sphere_y, sphere_z};

  // Integer part of the position (floor) relative to the sphere centre.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      ipos[i] = pos_q[i] >>> FRAC_BITS;
      diff[i] = ipos[i] - sph_q[i];
    end
  end

  ray_dist_sq u_dist (
    .dx      (diff[0]),
    .dy      (diff[1]),
    .dz      (diff[2]),
    .dist2_c (dist2_c)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      in_ready_q   <= 1'b1;
      out_valid_q  <= 1'b0;
      hit_q        <= 1'b0;
      step_cnt_q   <= '0;
      step_count_q <= '0;
      rad_q        <= '0;
      for (int i = 0; i < 3; i++) begin
        pos_q[i]     <= '0;
        delta_q[i]   <= '0;
        sph_q[i]     <= '0;
        hit_pos_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      in_ready_q   <= in_ready_d;
      out_valid_q  <= out_valid_d;
      hit_q        <= hit_d;
      step_cnt_q   <= step_cnt_d;
      step_count_q <= step_count_d;
      rad_q        <= rad_d;
      for (int i = 0; i < 3; i++) begin
        pos_q[i]     <= pos_d[i];
        delta_q[i]   <= delta_d[i];
        sph_q[i]     <= sph_d[i];
        hit_pos_q[i] <= hit_pos_d[i];
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    out_valid_d  = 1'b0;
    hit_d        = hit_q;
    step_cnt_d   = step_cnt_q;
    step_count_d = step_count_q;
    rad_d        = rad_q;
    pos_d        = pos_q;
    delta_d      = delta_q;
    sph_d        = sph_q;
    hit_pos_d    = hit_pos_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          for (int i = 0; i < 3; i++) begin
            pos_d[i]   = COORD_W'({cam_in[i], {FRAC_BITS{1'b0}}});
            delta_d[i] = dir_in[i] <<< DELTA_SHIFT;
            sph_d[i]   = sph_in[i];
          end
          rad_d      = radius_sq;
          step_cnt_d = '0;
          state_d    = TEST;
        end
      end
      TEST: begin
        if (dist2_c <= DIST_W'(rad_q) || step_cnt_q == STEP_W'(MAX_STEPS)) begin
          hit_d        = (dist2_c <= DIST_W'(rad_q));
          step_count_d = step_cnt_q;
          hit_pos_d    = ipos;
          state_d      = DONE;
        end else begin
          state_d = STEP;
        end
      end
      STEP: begin
        for (int i = 0; i < 3; i++) begin
          pos_d[i] = pos_q[i] + delta_q[i];
        end
        step_cnt_d = step_cnt_q + STEP_W'(1);
        state_d    = TEST;
      end
      DONE: begin
        // out_valid trails DONE entry by one cycle; the result registers are already stable.
        out_valid_d = 1'b1;
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Registered decode of the next state so in_ready is flop-driven.
  always_comb begin
    in_ready_d = (state_d == IDLE);
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign hit        = hit_q;
  assign step_count = step_count_q;
  assign hit_x      = hit_pos_q[0];
  assign hit_y      = hit_pos_q[1];
  assign hit_z      = hit_pos_q[2];

endmodule

// File: tb/tb_ray_marcher.sv
// Directed self-checking bench for ray_marcher, built with a 31-step budget.
module tb_ray_marcher;

  localparam int unsigned MAXS = 31;
  localparam int unsigned SW   = $clog2(MAXS + 1);

  logic               clk = 1'b0;
  logic               reset_n;
  logic               in_valid;
  logic               in_ready;
  logic        [10:0] camera_pos_x, camera_pos_y, camera_pos_z;
  logic signed [31:0] ray_dir_x, ray_dir_y, ray_dir_z;
  logic signed [31:0] sphere_x, sphere_y, sphere_z;
  logic        [63:0] radius_sq;
  logic               out_valid;
  logic               out_ready;
  logic               hit;
  logic      [SW-1:0] step_count;
  logic signed [31:0] hit_x, hit_y, hit_z;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ray_marcher #(.MAX_STEPS(MAXS)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .camera_pos_x(camera_pos_x), .camera_pos_y(camera_pos_y), .camera_pos_z(camera_pos_z),
    .ray_dir_x(ray_dir_x), .ray_dir_y(ray_dir_y), .ray_dir_z(ray_dir_z),
    .sphere_x(sphere_x), .sphere_y(sphere_y), .sphere_z(sphere_z),
    .radius_sq(radius_sq),
    .out_valid(out_valid), .out_ready(out_ready),
    .hit(hit), .step_count(step_count),
    .hit_x(hit_x), .hit_y(hit_y), .hit_z(hit_z)
  );

  // Present a ray, accept it, scramble the inputs, then count cycles until out_valid.
  task automatic run_ray(input int cx, cy, cz, dx, dy, dz, sx, sy, sz,
                         input longint unsigned r, output int lat);
    int n;
    n = 0;
    while (!in_ready && n < 100) begin
      @(posedge clk); #1; n++;
    end
    camera_pos_x = 11'(cx); camera_pos_y = 11'(cy); camera_pos_z = 11'(cz);
    ray_dir_x = dx; ray_dir_y = dy; ray_dir_z = dz;
    sphere_x = sx; sphere_y = sy; sphere_z = sz;
    radius_sq = r;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    camera_pos_x = 11'h7ff; camera_pos_y = 11'h7ff; camera_pos_z = 11'h7ff;
    sphere_x = 32'sd12345; sphere_y = -32'sd777; sphere_z = 32'sd999;
    radius_sq = '1;
    lat = 0;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1; lat++;
    end
    if (!out_valid) begin
      errors++; checks++;
      $display("FAIL run_ray_timeout: out_valid never rose within %0d cycles", lat);
    end
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    camera_pos_x = '0; camera_pos_y = '0; camera_pos_z = '0;
    ray_dir_x = '0; ray_dir_y = '0; ray_dir_z = '0;
    sphere_x = '0; sphere_y = '0; sphere_z = '0; radius_sq = '0;
    #23;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++; if (hit !== 1'b0) begin errors++; $display("FAIL reset_hit: got %b want 0", hit); end
    checks++; if (step_count !== '0) begin errors++; $display("FAIL reset_step_count: got %0d want 0", step_count); end
    checks++; if ({hit_x, hit_y, hit_z} !== 96'd0) begin errors++; $display("FAIL reset_hit_pos: got %0d,%0d,%0d want 0,0,0", hit_x, hit_y, hit_z); end
    reset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_straight_hit();
    int lat;
    run_ray(0, 0, 0, 0, 0, 16, 0, 0, 10, 64'd4, lat);
    checks++; if (lat !== 18) begin errors++; $display("FAIL straight_latency: got %0d want 18", lat); end
    checks++; if (hit !== 1'b1) begin errors++; $display("FAIL straight_hit: got %b want 1", hit); end
    checks++; if (step_count !== 8) begin errors++; $display("FAIL straight_steps: got %0d want 8", step_count); end
    checks++; if (hit_x !== 0 || hit_y !== 0 || hit_z !== 8) begin errors++; $display("FAIL straight_pos: got %0d,%0d,%0d want 0,0,8", hit_x, hit_y, hit_z); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL straight_in_ready_busy: got %b want 0", in_ready); end
    release_result();
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL straight_release: got ov=%b ir=%b want 0,1", out_valid, in_ready); end
  endtask

  task automatic test_inside();
    int lat;
    run_ray(0, 0, 10, 0, 0, 16, 0, 0, 10, 64'd4, lat);
    checks++; if (lat !== 2) begin errors++; $display("FAIL inside_latency: got %0d want 2", lat); end
    checks++; if (hit !== 1'b1 || step_count !== 0) begin errors++; $display("FAIL inside_result: got hit=%b steps=%0d want 1,0", hit, step_count); end
    checks++; if (hit_x !== 0 || hit_y !== 0 || hit_z !== 10) begin errors++; $display("FAIL inside_pos: got %0d,%0d,%0d want 0,0,10", hit_x, hit_y, hit_z); end
    release_result();
  endtask

  task automatic test_miss();
    int lat;
    run_ray(0, 0, 0, 0, 16, 16, 0, 0, 10, 64'd4, lat);
    checks++; if (lat !== 64) begin errors++; $display("FAIL miss_latency: got %0d want 64", lat); end
    checks++; if (hit !== 1'b0 || step_count !== 31) begin errors++; $display("FAIL miss_result: got hit=%b steps=%0d want 0,31", hit, step_count); end
    checks++; if (hit_x !== 0 || hit_y !== 31 || hit_z !== 31) begin errors++; $display("FAIL miss_pos: got %0d,%0d,%0d want 0,31,31", hit_x, hit_y, hit_z); end
    release_result();
  endtask

  task automatic test_floor();
    int lat;
    run_ray(0, 0, 0, -8, 0, 16, -3, 0, 6, 64'd0, lat);
    checks++; if (lat !== 14) begin errors++; $display("FAIL floor_latency: got %0d want 14", lat); end
    checks++; if (hit !== 1'b1 || step_count !== 6) begin errors++; $display("FAIL floor_result: got hit=%b steps=%0d want 1,6", hit, step_count); end
    checks++; if (hit_x !== -3 || hit_y !== 0 || hit_z !== 6) begin errors++; $display("FAIL floor_pos: got %0d,%0d,%0d want -3,0,6", hit_x, hit_y, hit_z); end
    release_result();
  endtask

  task automatic test_zero_dir_miss();
    int lat;
    run_ray(0, 0, 0, 0, 0, 0, 0, 0, 10, 64'd4, lat);
    checks++; if (hit !== 1'b0 || step_count !== 31 || hit_z !== 0) begin errors++; $display("FAIL zero_dir: got hit=%b steps=%0d z=%0d want 0,31,0", hit, step_count, hit_z); end
    release_result();
  endtask

  task automatic test_backpressure();
    int lat;
    int bad;
    run_ray(0, 0, 0, 0, 0, 16, 0, 0, 10, 64'd4, lat);
    // Offer a second ray while the first result is stalled.
    camera_pos_x = '0; camera_pos_y = '0; camera_pos_z = 11'd10;
    ray_dir_x = 0; ray_dir_y = 0; ray_dir_z = 16;
    sphere_x = 0; sphere_y = 0; sphere_z = 10; radius_sq = 64'd4;
    in_valid = 1'b1;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || hit !== 1'b1 || step_count !== 8 || hit_z !== 8) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL bp_hold: got %0d unstable cycles want 0", bad); end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL bp_release: got ir=%b ov=%b want 1,0", in_ready, out_valid); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_next_accept: got in_ready=%b want 0", in_ready); end
    lat = 0;
    while (!out_valid && lat < 50) begin
      @(posedge clk); #1; lat++;
    end
    checks++; if (lat !== 2 || hit !== 1'b1 || step_count !== 0 || hit_z !== 10) begin errors++; $display("FAIL bp_next_result: got lat=%0d hit=%b steps=%0d z=%0d want 2,1,0,10", lat, hit, step_count, hit_z); end
    release_result();
  endtask

  task automatic test_reset_mid_march();
    int lat;
    camera_pos_x = '0; camera_pos_y = '0; camera_pos_z = '0;
    ray_dir_x = 0; ray_dir_y = 0; ray_dir_z = 16;
    sphere_x = 0; sphere_y = 0; sphere_z = 10; radius_sq = 64'd4;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (7) begin @(posedge clk); end
    #3;
    reset_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL midreset_handshake: got ov=%b ir=%b want 0,1", out_valid, in_ready); end
    checks++; if (hit !== 1'b0 || step_count !== 0 || hit_x !== 0 || hit_y !== 0 || hit_z !== 0) begin errors++; $display("FAIL midreset_outputs: got hit=%b steps=%0d z=%0d want 0,0,0", hit, step_count, hit_z); end
    @(posedge clk); #3;
    reset_n = 1'b1;
    @(posedge clk); #1;
    run_ray(0, 0, 0, 0, 0, 16, 0, 0, 10, 64'd4, lat);
    checks++; if (lat !== 18 || hit !== 1'b1 || step_count !== 8 || hit_z !== 8) begin errors++; $display("FAIL midreset_rerun: got lat=%0d hit=%b steps=%0d z=%0d want 18,1,8,8", lat, hit, step_count, hit_z); end
    release_result();
  endtask

  initial begin
    test_reset();
    test_straight_hit();
    test_inside();
    test_miss();
    test_floor();
    test_zero_dir_miss();
    test_backpressure();
    test_reset_mid_march();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
